line_window_gen: RTL

- Parametrised sliding-window generator for 2D streaming image filters.
- Takes a raster pixel stream (pixel plus dv/hs/vs), buffers KERNEL-1 lines in dual-port RAM, and presents a full KERNEL x KERNEL window each accepted pixel.
- Adds valid-region gating, line-overflow detection and aligned sync outputs.
- Sits between the video input and the convolution/MAC stage.

---
 rtl/line_window_gen.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/line_window_gen.sv
// line_window_gen: KERNEL x KERNEL sliding-window generator for a raster
// pixel stream. KERNEL-1 cascaded line buffers feed a shifting window.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   pix_i        input pixel (DATA_W bits)
//   dv_i         pixel valid
//   hs_i         horizontal sync, rising edge ends the current line
//   vs_i         vertical sync, high restarts the frame
//   window_o     element (r,c) at [(r*KERNEL+c)*DATA_W +: DATA_W],
//                r=0 newest line, c=0 newest column
//   win_valid_o  window lies fully inside the image
//   dv_o         accepted-pixel strobe aligned with window_o
//   hs_o, vs_o   syncs aligned with window_o
//   ovf_o        sticky: a line exceeded MAX_COLS in this frame
//   cx_o, cy_o   window-centre coordinates (only with LINE_WINDOW_COORD_EN)
//
// Optional macro: LINE_WINDOW_COORD_EN adds cx_o/cy_o and a full row counter.

module line_window_gen #(
  parameter int DATA_W   = 8,
  parameter int KERNEL   = 5,
  parameter int MAX_COLS = 1608,
  parameter int COL_W    = 11
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_W-1:0]               pix_i,
  input  logic                            dv_i,
  input  logic                            hs_i,
  input  logic                            vs_i,
  output logic [KERNEL*KERNEL*DATA_W-1:0] window_o,
  output logic                            win_valid_o,
  output logic                            dv_o,
  output logic                            hs_o,
  output logic                            vs_o,
`ifdef LINE_WINDOW_COORD_EN
  output logic [COL_W-1:0]                cx_o,
  output logic [COL_W-1:0]                cy_o,
`endif
  output logic                            ovf_o
);

  localparam int RW = $clog2(KERNEL);
  localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

  localparam logic [COL_W-1:0] C_MAX  = COL_W'(MAX_COLS);
  localparam logic [COL_W-1:0] C_KM1  = COL_W'(KERNEL - 1);
  localparam logic [RW-1:0]    R_KM1  = RW'(KERNEL - 1);
`ifdef LINE_WINDOW_COORD_EN
  localparam logic [COL_W-1:0] C_HALF = COL_W'(KERNEL / 2);
`endif

  // ---------------------------------------------------------------
  // Input stage: accept decision and raster counters
  // ---------------------------------------------------------------
  logic [COL_W-1:0] r_col;
  logic [RW-1:0]    r_row;
  logic             r_hs_q;

  logic w_hs_rise;
  logic w_room;
  logic w_acc;
  logic w_drop;
  logic w_line_nz;

  assign w_hs_rise = hs_i & ~r_hs_q;
  assign w_room    = (r_col < C_MAX);
  assign w_acc     = dv_i & ~vs_i & w_room;
  assign w_drop    = dv_i & ~vs_i & ~w_room;
  // A pixel arriving with the hs edge still belongs to the closing line.
  assign w_line_nz = (r_col != '0) | w_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_hs_q <= 1'b0;
    end else begin
      r_hs_q <= hs_i;
      if (vs_i) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_hs_rise) begin
        r_col <= '0;
        if (w_line_nz && (r_row != R_KM1))
          r_row <= r_row + 1'b1;
      end else if (w_acc) begin
        r_col <= r_col + 1'b1;
      end
    end
  end

`ifdef LINE_WINDOW_COORD_EN
  logic [COL_W-1:0] r_row_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_f <= '0;
    end else if (vs_i) begin
      r_row_f <= '0;
    end else if (w_hs_rise && w_line_nz) begin
      r_row_f <= r_row_f + 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------
  // Stage 1: pixel and position travelling alongside the RAM read
  // ---------------------------------------------------------------
  logic              r_acc_d1;
  logic              r_drop_d1;
  logic              r_hs_d1;
  logic              r_vs_d1;
  logic [DATA_W-1:0] r_pix_d1;
  logic [COL_W-1:0]  r_col_d1;
  logic [RW-1:0]     r_row_d1;
`ifdef LINE_WINDOW_COORD_EN
  logic [COL_W-1:0]  r_row_f_d1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_d1  <= 1'b0;
      r_drop_d1 <= 1'b0;
      r_hs_d1   <= 1'b0;
      r_vs_d1   <= 1'b0;
      r_pix_d1  <= '0;
      r_col_d1  <= '0;
      r_row_d1  <= '0;
    end else begin
      r_acc_d1  <= w_acc;
      r_drop_d1 <= w_drop;
      r_hs_d1   <= hs_i;
      r_vs_d1   <= vs_i;
      r_pix_d1  <= pix_i;
      r_col_d1  <= r_col;
      r_row_d1  <= r_row;
    end
  end

`ifdef LINE_WINDOW_COORD_EN
  always_ff @(posedge clk) begin
    if (rst) r_row_f_d1 <= '0;
    else     r_row_f_d1 <= r_row_f;
  end
`endif

  // ---------------------------------------------------------------
  // Line buffers: RAM j holds line n-1-j. Each RAM is read at the
  // current column and rewritten one cycle later with the line one
  // step newer, so the whole cascade advances by one line per line.
  // ---------------------------------------------------------------
  logic [AW-1:0]     w_raddr;
  logic [AW-1:0]     w_waddr;
  logic [DATA_W-1:0] w_col [KERNEL];

  assign w_raddr  = r_col[AW-1:0];
  assign w_waddr  = r_col_d1[AW-1:0];
  assign w_col[0] = r_pix_d1;

  for (genvar j = 0; j < KERNEL - 1; j++) begin : g_lb
    logic [DATA_W-1:0] r_mem [MAX_COLS];
    logic [DATA_W-1:0] r_rd;

    // Same-address read and write (one-pixel lines) forward the new
    // data so the cascade stays consistent.
    always_ff @(posedge clk) begin
      if (r_acc_d1)
        r_mem[w_waddr] <= w_col[j];
      if (r_acc_d1 && (w_waddr == w_raddr))
        r_rd <= w_col[j];
      else
        r_rd <= r_mem[w_raddr];
    end

    assign w_col[j+1] = r_rd;
  end

  // ---------------------------------------------------------------
  // Stage 2: window shift register and aligned outputs
  // ---------------------------------------------------------------
  logic [DATA_W-1:0] r_win [KERNEL][KERNEL];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < KERNEL; r++)
        for (int c = 0; c < KERNEL; c++)
          r_win[r][c] <= '0;
    end else if (r_acc_d1) begin
      for (int r = 0; r < KERNEL; r++) begin
        r_win[r][0] <= w_col[r];
        for (int c = 1; c < KERNEL; c++)
          r_win[r][c] <= r_win[r][c-1];
      end
    end
  end

  for (genvar r = 0; r < KERNEL; r++) begin : g_wr
    for (genvar c = 0; c < KERNEL; c++) begin : g_wc
      assign window_o[(r*KERNEL+c)*DATA_W +: DATA_W] = r_win[r][c];
    end
  end

  logic w_wv_d1;

  assign w_wv_d1 = r_acc_d1 & (r_col_d1 >= C_KM1) & (r_row_d1 == R_KM1);

  logic r_wv;
  logic r_dv;
  logic r_hs;
  logic r_vs;
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wv <= 1'b0;
      r_dv <= 1'b0;
      r_hs <= 1'b0;
      r_vs <= 1'b0;
    end else begin
      r_wv <= w_wv_d1;
      r_dv <= r_acc_d1;
      r_hs <= r_hs_d1;
      r_vs <= r_vs_d1;
    end
  end

  // Overflow flag rises with the dropped pixel's pipeline slot and
  // is cleared as soon as a new frame starts.
  always_ff @(posedge clk) begin
    if (rst)            r_ovf <= 1'b0;
    else if (vs_i)      r_ovf <= 1'b0;
    else if (r_drop_d1) r_ovf <= 1'b1;
  end

  assign win_valid_o = r_wv;
  assign dv_o        = r_dv;
  assign hs_o        = r_hs;
  assign vs_o        = r_vs;
  assign ovf_o       = r_ovf;

`ifdef LINE_WINDOW_COORD_EN
  logic [COL_W-1:0] r_cx;
  logic [COL_W-1:0] r_cy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (w_wv_d1) begin
      r_cx <= r_col_d1 - C_HALF;
      r_cy <= r_row_f_d1 - C_HALF;
    end else begin
      r_cx <= '0;
      r_cy <= '0;
    end
  end

  assign cx_o = r_cx;
  assign cy_o = r_cy;
`endif

endmodule
